// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the hazard/forwarding control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  // Tracked rd is held at a fixed width so one struct serves every REG_ADDR_W up to 8.
  localparam int TRK_RD_W = 8;
  typedef logic [TRK_RD_W-1:0] trk_rd_t;

  typedef struct packed {
    logic    valid;
    trk_rd_t rd;
    logic    is_load;
  } trk_entry_t;

  localparam int FWD_REGFILE = 0;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_REG  = 7'b0110011;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Decode-side bundle between the decode stage and hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int CNT_W      = 32
) ();

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_rd_we;
  logic                  id_is_load;
  logic                  redirect;

  logic                  stall;
  logic                  flush_id;
  logic [SEL_W-1:0]      fwd_sel1;
  logic [SEL_W-1:0]      fwd_sel2;
  logic                  flush_active;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, redirect,
    input  stall, flush_id, fwd_sel1, fwd_sel2, flush_active,
           stall_cycles, flush_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, redirect,
    output stall, flush_id, fwd_sel1, fwd_sel2, flush_active,
           stall_cycles, flush_cycles
  );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_prio_enc.sv
// ============================================================================
// Module      : fwd_prio_enc
// Description : Youngest-producer priority encoder for one source operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_prio_enc
  import hazard_pkg::*;
#(
  parameter int FWD_DEPTH = 3,
  parameter int SEL_W     = 2
) (
  input  trk_entry_t       trk [FWD_DEPTH],
  input  trk_rd_t          rs,
  input  logic             rs_used,
  output logic [SEL_W-1:0] sel
);

  // Scan oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    sel = SEL_W'(FWD_REGFILE);
    if (rs_used && (rs != '0)) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (trk[k].valid && (trk[k].rd == rs) && !((k == 0) && trk[k].is_load)) begin
          sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Destination tracking, forwarding selects, load-use stall,
//               branch flush window and stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int FWD_DEPTH      = 3,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 32
) (
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);
  localparam int FC_W  = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(BRANCH_PENALTY - 1);

  trk_entry_t       trk_q [FWD_DEPTH];
  trk_entry_t       trk_d [FWD_DEPTH];
  fsm_state_t       state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             flush_active_q, flush_active_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  trk_rd_t          rs1_x, rs2_x, rd_x;
  logic             load_use;
  logic             flush_raw;
  logic             stall_raw;
  logic [SEL_W-1:0] sel1_raw, sel2_raw;

  assign rs1_x = trk_rd_t'(bus.id_rs1);
  assign rs2_x = trk_rd_t'(bus.id_rs2);
  assign rd_x  = trk_rd_t'(bus.id_rd);

  fwd_prio_enc #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_enc_rs1 (
    .trk     (trk_q),
    .rs      (rs1_x),
    .rs_used (bus.id_rs1_used),
    .sel     (sel1_raw)
  );

  fwd_prio_enc #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_enc_rs2 (
    .trk     (trk_q),
    .rs      (rs2_x),
    .rs_used (bus.id_rs2_used),
    .sel     (sel2_raw)
  );

  always_comb begin
    flush_raw = bus.redirect | (state_q == FLUSH);
    load_use  = bus.id_valid & trk_q[0].valid & trk_q[0].is_load &
                ((bus.id_rs1_used & (rs1_x == trk_q[0].rd)) |
                 (bus.id_rs2_used & (rs2_x == trk_q[0].rd)));
    stall_raw = load_use & ~flush_raw;
  end

  // Downstream stages never stall, so the tracker shifts unconditionally.
  always_comb begin
    for (int k = 1; k < FWD_DEPTH; k++) begin
      trk_d[k] = trk_q[k-1];
    end
    trk_d[0] = '0;
    if (!(stall_raw || flush_raw)) begin
      trk_d[0].valid   = bus.id_valid & bus.id_rd_we & (rd_x != '0);
      trk_d[0].rd      = rd_x;
      trk_d[0].is_load = bus.id_is_load;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (bus.redirect && (BRANCH_PENALTY > 1)) begin
          state_d = FLUSH;
          fcnt_d  = FC_RELOAD;
        end
      end
      FLUSH: begin
        if (bus.redirect) begin
          fcnt_d = FC_RELOAD;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
          if (fcnt_d == '0) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    endcase
    flush_active_d = (state_d == FLUSH);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_raw && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_raw && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        trk_q[k] <= '0;
      end
      state_q        <= RUN;
      fcnt_q         <= '0;
      flush_active_q <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        trk_q[k] <= trk_d[k];
      end
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      flush_active_q <= flush_active_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign bus.stall        = stall_raw & ~reset;
  assign bus.flush_id     = flush_raw & ~reset;
  assign bus.fwd_sel1     = reset ? '0 : sel1_raw;
  assign bus.fwd_sel2     = reset ? '0 : sel2_raw;
  assign bus.flush_active = flush_active_q;
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_cycles = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed and random checks of hazard_ctrl against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int DEPTH = 3;
  localparam int BP    = 3;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  hazard_ctrl_if #(.REG_ADDR_W(5), .FWD_DEPTH(DEPTH), .CNT_W(32)) bus ();
  hazard_ctrl_if #(.REG_ADDR_W(5), .FWD_DEPTH(DEPTH), .CNT_W(3))  bus2 ();

  hazard_ctrl #(.REG_ADDR_W(5), .FWD_DEPTH(DEPTH), .BRANCH_PENALTY(BP), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .FWD_DEPTH(DEPTH), .BRANCH_PENALTY(1), .CNT_W(3)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    bit v;
    int rd;
    bit ld;
  } ent_t;

  ent_t    pipe[$];
  int      total = 0;
  int      bad   = 0;
  int      fl_left;
  longint  m_stall_cnt, m_flush_cnt;
  int      m_cnt2;
  bit      known = 0;
  bit      e_stall, e_flush;
  int      e_sel1, e_sel2;
  longint  base;
  int      nhi;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_sel(input int rs, input bit used);
    if (!used || rs == 0) return 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (pipe[k].v && pipe[k].rd == rs && !(k == 0 && pipe[k].ld)) return k + 1;
    end
    return 0;
  endfunction

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input logic [6:0] opc, input bit redir);
    bus.id_valid    = v;
    bus.id_rs1      = 5'(rs1);
    bus.id_rs1_used = u1;
    bus.id_rs2      = 5'(rs2);
    bus.id_rs2_used = u2;
    bus.id_rd       = 5'(rd);
    bus.id_rd_we    = we;
    bus.id_is_load  = (opc == OPC_LOAD);
    bus.redirect    = redir;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, OPC_IMM, 0);
  endtask

  task automatic settle_check();
    bit lu;
    @(negedge clock);
    e_flush = bus.redirect || (fl_left > 0);
    lu = bus.id_valid && pipe[0].v && pipe[0].ld &&
         ((bus.id_rs1_used && int'(bus.id_rs1) == pipe[0].rd) ||
          (bus.id_rs2_used && int'(bus.id_rs2) == pipe[0].rd));
    e_stall = lu && !e_flush;
    e_sel1  = model_sel(int'(bus.id_rs1), bus.id_rs1_used);
    e_sel2  = model_sel(int'(bus.id_rs2), bus.id_rs2_used);
    if (reset) begin
      e_flush = 0;
      e_stall = 0;
      e_sel1  = 0;
      e_sel2  = 0;
    end
    check("stall", bus.stall, e_stall);
    check("flush_id", bus.flush_id, e_flush);
    check("fwd_sel1", bus.fwd_sel1, e_sel1);
    check("fwd_sel2", bus.fwd_sel2, e_sel2);
    check("sat_flush_id", bus2.flush_id, reset ? 1'b0 : bus2.redirect);
    if (known) begin
      check("flush_active", bus.flush_active, fl_left > 0);
      check("stall_cycles", bus.stall_cycles, m_stall_cnt);
      check("flush_cycles", bus.flush_cycles, m_flush_cnt);
      check("sat_flush_cycles", bus2.flush_cycles, m_cnt2);
      check("sat_flush_active", bus2.flush_active, 1'b0);
    end
  endtask

  task automatic tick();
    ent_t n;
    @(posedge clock);
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] = '{0, 0, 0};
      fl_left     = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      m_cnt2      = 0;
    end else begin
      n.v  = !(e_stall || e_flush) && bus.id_valid && bus.id_rd_we && (bus.id_rd != 0);
      n.rd = int'(bus.id_rd);
      n.ld = bus.id_is_load;
      pipe.push_front(n);
      void'(pipe.pop_back());
      if (bus.redirect) fl_left = BP - 1;
      else if (fl_left > 0) fl_left--;
      if (e_stall) m_stall_cnt++;
      if (e_flush) m_flush_cnt++;
      if (bus2.redirect && m_cnt2 < 7) m_cnt2++;
    end
    known = 1;
    #1;
  endtask

  task automatic step();
    settle_check();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) pipe.push_back('{0, 0, 0});
    fl_left = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    m_cnt2 = 0;
    bus2.id_valid = 0; bus2.id_rs1 = 0; bus2.id_rs2 = 0; bus2.id_rs1_used = 0;
    bus2.id_rs2_used = 0; bus2.id_rd = 0; bus2.id_rd_we = 0; bus2.id_is_load = 0;
    bus2.redirect = 0;

    // Reset held with live decode and redirect; outputs must be forced low.
    reset = 1;
    drive(1, 5, 1, 6, 1, 5, 1, OPC_LOAD, 1);
    step();
    settle_check();
    check("rst_flush", bus.flush_id, 1'b0);
    check("rst_stall_cnt", bus.stall_cycles, 0);
    tick();
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0, OPC_IMM, 1);
    settle_check();
    check("rst_exit_flush", bus.flush_id, 1'b1);
    tick();
    idle();
    repeat (4) step();

    // Back-to-back ALU forwarding as the producer ages through the tracker.
    drive(1, 0, 0, 0, 0, 5, 1, OPC_IMM, 0);
    step();
    drive(1, 5, 1, 0, 0, 0, 0, OPC_REG, 0);
    settle_check(); check("alu_ex", bus.fwd_sel1, 1); tick();
    settle_check(); check("alu_mem", bus.fwd_sel1, 2); tick();
    settle_check(); check("alu_wb", bus.fwd_sel1, 3); tick();
    settle_check(); check("alu_gone", bus.fwd_sel1, 0); tick();

    // Load-use on rs2.
    idle(); step();
    drive(1, 0, 0, 0, 0, 7, 1, OPC_LOAD, 0);
    step();
    drive(1, 1, 1, 7, 1, 8, 1, OPC_REG, 0);
    settle_check(); check("lu_stall", bus.stall, 1); tick();
    settle_check();
    check("lu_release", bus.stall, 0);
    check("lu_fwd2", bus.fwd_sel2, 2);
    check("lu_count", bus.stall_cycles, 1);
    tick();

    // Youngest producer wins; x0 never forwards.
    idle(); repeat (3) step();
    drive(1, 0, 0, 0, 0, 3, 1, OPC_IMM, 0); step();
    idle(); step();
    drive(1, 0, 0, 0, 0, 3, 1, OPC_REG, 0); step();
    drive(1, 3, 1, 0, 0, 0, 0, OPC_REG, 0);
    settle_check(); check("youngest", bus.fwd_sel1, 1); tick();
    drive(1, 0, 0, 0, 0, 0, 1, OPC_IMM, 0); step(); step();
    drive(1, 0, 1, 0, 1, 0, 0, OPC_REG, 0);
    settle_check();
    check("x0_sel1", bus.fwd_sel1, 0);
    check("x0_sel2", bus.fwd_sel2, 0);
    tick();

    // Single redirect: three flush cycles, flush_active on the last two.
    idle(); repeat (3) step();
    base = m_flush_cnt;
    drive(0, 0, 0, 0, 0, 0, 0, OPC_IMM, 1);
    settle_check(); check("win0_active", bus.flush_active, 0); tick();
    idle();
    settle_check(); check("win1_flush", bus.flush_id, 1); check("win1_active", bus.flush_active, 1); tick();
    settle_check(); check("win2_flush", bus.flush_id, 1); check("win2_active", bus.flush_active, 1); tick();
    settle_check(); check("win3_flush", bus.flush_id, 0); check("win_count", bus.flush_cycles, base + 3); tick();

    // Redirect again in the second flush cycle stretches the window to four.
    idle(); step();
    base = m_flush_cnt;
    drive(0, 0, 0, 0, 0, 0, 0, OPC_IMM, 1); step();
    step();
    idle();
    nhi = 2;
    for (int i = 0; i < 5; i++) begin
      settle_check();
      if (bus.flush_id) nhi++;
      tick();
    end
    check("retrig_len", nhi, 4);
    check("retrig_count", bus.flush_cycles, base + 4);

    // Redirect coincides with a load-use: flush wins, no stall counted.
    drive(1, 0, 0, 0, 0, 9, 1, OPC_LOAD, 0); step();
    drive(1, 9, 1, 0, 0, 0, 0, OPC_REG, 1);
    settle_check(); check("lu_redir_flush", bus.flush_id, 1); check("lu_redir_stall", bus.stall, 0); tick();
    idle();
    settle_check(); check("lu_redir_cnt", bus.stall_cycles, 1); tick();
    repeat (3) step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int pick;
      logic [6:0] opc;
      pick = int'($urandom_range(0, 2));
      opc  = (pick == 0) ? OPC_LOAD : ((pick == 1) ? OPC_IMM : OPC_REG);
      drive($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)), 1'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
            1'($urandom), opc, $urandom_range(0, 9) == 0);
      step();
    end

    // Saturation of the narrow counter instance.
    idle();
    bus2.redirect = 1;
    repeat (10) step();
    settle_check();
    check("sat_value", bus2.flush_cycles, 7);
    tick();
    bus2.redirect = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
